// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the sequencer state enum, port indices and small helpers.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned PORT_CORE   = 0;
  localparam int unsigned PORT_LOADER = 1;
  localparam int unsigned LAT_W       = 4;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin picker.
// A lone requester always wins; on a tie, the port that did not win last time wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] REQ,
  input  logic       LAST,
  output logic       VALID,
  output logic       WIN
);

  always_comb begin
    VALID = |REQ;
    WIN   = 1'(PORT_CORE);
    case (REQ)
      2'b01:   WIN = 1'(PORT_CORE);
      2'b10:   WIN = 1'(PORT_LOADER);
      2'b11:   WIN = ~LAST;
      default: WIN = 1'(PORT_CORE);
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises the core and loader/debug ports onto the single Memoria64 data port.
// Optional DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
//
// state | meaning
// IDLE  | waiting for a request; winner and its command are latched here
// ISSUE | one-cycle grant; write strobe fires or the read latency timer is loaded
// WAIT  | read address held while the latency timer counts down
// RESP  | one-cycle RVALID to the winner with captured read data
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ,
  input  logic [1:0]        WE,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [1:0]        GNT,
  output logic [1:0]        RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] MEM_RADDR,
  output logic [ADDR_W-1:0] MEM_WADDR,
  output logic [DATA_W-1:0] MEM_DATAIN,
  output logic              MEM_WR,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]       GNT_CNT0,
  output logic [31:0]       GNT_CNT1,
  output logic [31:0]       CONFLICT_CNT,
`endif
  input  logic [DATA_W-1:0] MEM_DATAOUT
);

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;

  logic pick_valid;
  logic pick_win;

  dmem_rr_pick u_pick (
    .REQ   (REQ),
    .LAST  (last_q),
    .VALID (pick_valid),
    .WIN   (pick_win)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d   = pick_win;
          we_d    = WE[pick_win];
          addr_d  = pick_win ? ADDR1 : ADDR0;
          wdata_d = pick_win ? WDATA1 : WDATA0;
          last_d  = pick_win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = LAT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt_q==1 is the cycle the timer reaches zero: MEM_DATAOUT is valid now
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          rdata_d = MEM_DATAOUT;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    GNT    = 2'b00;
    RVALID = 2'b00;
    MEM_WR = 1'b0;
    case (state_q)
      ISSUE: begin
        GNT    = port_onehot(win_q);
        MEM_WR = we_q;
      end
      RESP:    RVALID = port_onehot(win_q);
      default: ;
    endcase
  end

  assign MEM_RADDR  = addr_q;
  assign MEM_WADDR  = addr_q;
  assign MEM_DATAIN = wdata_q;
  assign RDATA      = rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gnt_cnt0_q, gnt_cnt1_q, conflict_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      gnt_cnt0_q     <= '0;
      gnt_cnt1_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (state_q == ISSUE && win_q == 1'(PORT_CORE))
        gnt_cnt0_q <= sat_inc32(gnt_cnt0_q);
      if (state_q == ISSUE && win_q == 1'(PORT_LOADER))
        gnt_cnt1_q <= sat_inc32(gnt_cnt1_q);
      if (state_q == IDLE && REQ == 2'b11)
        conflict_cnt_q <= sat_inc32(conflict_cnt_q);
    end
  end

  assign GNT_CNT0     = gnt_cnt0_q;
  assign GNT_CNT1     = gnt_cnt1_q;
  assign CONFLICT_CNT = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// driven in parallel; a select flag chooses which instance each test checks.
module tb_dmem_port_arbiter;

  localparam int RN = 700;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr0, addr1, wdata0, wdata1;

  logic [1:0]  gnt1, rvalid1, gnt3, rvalid3;
  logic [63:0] rdata1, raddr1, waddr1, din1, dout1;
  logic [63:0] rdata3, raddr3, waddr3, din3, dout3;
  logic        wr1, wr3;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] g0_1, g1_1, cf_1, g0_3, g1_3, cf_3;
`endif

  bit          sel3;
  logic [1:0]  s_gnt, s_rvalid;
  logic        s_wr;
  logic [63:0] s_rdata, s_raddr, s_waddr, s_din;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst_n), .REQ(req), .WE(we),
    .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT(gnt1), .RVALID(rvalid1), .RDATA(rdata1),
    .MEM_RADDR(raddr1), .MEM_WADDR(waddr1), .MEM_DATAIN(din1), .MEM_WR(wr1),
`ifdef DMEM_ARB_STATS_EN
    .GNT_CNT0(g0_1), .GNT_CNT1(g1_1), .CONFLICT_CNT(cf_1),
`endif
    .MEM_DATAOUT(dout1)
  );

  dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst_n), .REQ(req), .WE(we),
    .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
    .GNT(gnt3), .RVALID(rvalid3), .RDATA(rdata3),
    .MEM_RADDR(raddr3), .MEM_WADDR(waddr3), .MEM_DATAIN(din3), .MEM_WR(wr3),
`ifdef DMEM_ARB_STATS_EN
    .GNT_CNT0(g0_3), .GNT_CNT1(g1_3), .CONFLICT_CNT(cf_3),
`endif
    .MEM_DATAOUT(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of address; data appears RD_LAT edges after the address.
  function automatic logic [63:0] memf(input logic [63:0] a);
    if (a == 64'h40) return 64'hDEADBEEF;
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  logic [63:0] p1;
  logic [63:0] p3 [3];
  always @(posedge clk) begin
    p1    <= raddr1;
    p3[0] <= raddr3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout1 = memf(p1);
  assign dout3 = memf(p3[2]);

  always_comb begin
    s_gnt    = sel3 ? gnt3    : gnt1;
    s_rvalid = sel3 ? rvalid3 : rvalid1;
    s_wr     = sel3 ? wr3     : wr1;
    s_rdata  = sel3 ? rdata3  : rdata1;
    s_raddr  = sel3 ? raddr3  : raddr1;
    s_waddr  = sel3 ? waddr3  : waddr1;
    s_din    = sel3 ? din3    : din1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction from IDLE with exact-cycle checks on the selected instance.
  task automatic txn(input bit p, input bit w, input logic [63:0] a, input logic [63:0] d,
                     input logic [1:0] exp_g, input logic [63:0] exp_d);
    int lat;
    lat = sel3 ? 3 : 1;
    @(negedge clk);
    req = p ? 2'b10 : 2'b01;
    we  = {w, w};
    if (p) begin addr1 = a; wdata1 = d; addr0 = ~a; wdata0 = ~d; end
    else   begin addr0 = a; wdata0 = d; addr1 = ~a; wdata1 = ~d; end
    @(negedge clk);
    check("gnt", s_gnt, exp_g);
    check("mem_wr", s_wr, w);
    check("mem_raddr", s_raddr, a);
    if (w) begin
      check("mem_waddr", s_waddr, a);
      check("mem_datain", s_din, exp_d);
    end
    req = 2'b00;
    if (!w) begin
      repeat (lat) begin
        @(negedge clk);
        check("rvalid_early", s_rvalid, 2'b00);
      end
      @(negedge clk);
      check("rvalid", s_rvalid, exp_g);
      check("rdata", s_rdata, exp_d);
    end else begin
      @(negedge clk);
      check("mem_wr_drop", s_wr, 1'b0);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  exp_gnt;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  // Random-test reference state: per-cycle expected events and per-port pending commands.
  logic [1:0]  e_gnt   [RN];
  logic        e_wr    [RN];
  logic [63:0] e_waddr [RN];
  logic [63:0] e_din   [RN];
  logic [1:0]  e_rv    [RN];
  logic [63:0] e_rdata [RN];
  logic [1:0]  rq;
  bit          rw [2];
  logic [63:0] ra [2];
  logic [63:0] rd [2];

  task automatic new_txn(input int p);
    rq[p] = 1'b1;
    rw[p] = 1'($urandom_range(1, 0));
    ra[p] = {$urandom, $urandom};
    rd[p] = {$urandom, $urandom};
  endtask

  task automatic rand_run(input int ncyc);
    int lat, free_at, g0, g1, cf;
    bit last, w, quiet;
    lat = sel3 ? 3 : 1;
    for (int i = 0; i < RN; i++) begin
      e_gnt[i] = 2'b00; e_wr[i] = 1'b0; e_waddr[i] = '0; e_din[i] = '0;
      e_rv[i] = 2'b00; e_rdata[i] = '0;
    end
    rq = 2'b00; free_at = 0; last = 1'b1; g0 = 0; g1 = 0; cf = 0;
    for (int k = 0; k < RN - 8; k++) begin
      @(negedge clk);
      check("rnd_gnt", s_gnt, e_gnt[k]);
      check("rnd_mem_wr", s_wr, e_wr[k]);
      check("rnd_rvalid", s_rvalid, e_rv[k]);
      if (e_wr[k]) begin
        check("rnd_waddr", s_waddr, e_waddr[k]);
        check("rnd_datain", s_din, e_din[k]);
      end
      if (e_rv[k] != 2'b00) check("rnd_rdata", s_rdata, e_rdata[k]);
      quiet = (k >= ncyc);
      if (quiet && rq == 2'b00 && k >= free_at + 2) break;
      for (int p = 0; p < 2; p++) begin
        if (e_gnt[k][p]) begin
          if (!quiet && $urandom_range(1, 0) == 1) new_txn(p);
          else rq[p] = 1'b0;
        end else if (!quiet && !rq[p] && $urandom_range(2, 0) == 0) begin
          new_txn(p);
        end
      end
      req = rq; we = {rw[1], rw[0]};
      addr0 = ra[0]; wdata0 = rd[0]; addr1 = ra[1]; wdata1 = rd[1];
      if (k >= free_at && rq != 2'b00) begin
        w = (rq == 2'b11) ? !last : rq[1];
        if (rq == 2'b11) cf++;
        if (w) g1++; else g0++;
        last = w;
        e_gnt[k+1] = w ? 2'b10 : 2'b01;
        if (rw[w]) begin
          e_wr[k+1] = 1'b1; e_waddr[k+1] = ra[w]; e_din[k+1] = rd[w];
          free_at = k + 2;
        end else begin
          e_rv[k+2+lat] = w ? 2'b10 : 2'b01;
          e_rdata[k+2+lat] = memf(ra[w]);
          free_at = k + 3 + lat;
        end
      end
    end
    check("rnd_drained", req, 2'b00);
`ifdef DMEM_ARB_STATS_EN
    check("rnd_gnt_cnt0", sel3 ? g0_3 : g0_1, g0);
    check("rnd_gnt_cnt1", sel3 ? g1_3 : g1_1, g1);
    check("rnd_conflict_cnt", sel3 ? cf_3 : cf_1, cf);
`endif
  endtask

  initial begin
    int sb_g0, sb_g1, sb_cf, ng, nrv, lastc, expp;
    bit p;
    logic [63:0] pa [2];

    vecs[0] = '{1'b0, 1'b0, 64'h40, 64'h0, 2'b01, 64'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 64'h100, 64'hAAAA_5555_AAAA_5555, 2'b10, 64'hAAAA_5555_AAAA_5555};
    vecs[2] = '{1'b0, 1'b1, 64'h0, 64'h1, 2'b01, 64'h1};
    vecs[3] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'b10, memf(64'hFFFF_FFFF_FFFF_FFF8)};
    vecs[4] = '{1'b0, 1'b1, '1, '1, 2'b01, '1};
    vecs[5] = '{1'b1, 1'b0, 64'h8, 64'h0, 2'b10, memf(64'h8)};

    sel3 = 1'b0;
    rst_n = 1'b0; req = 2'b11; we = 2'b00;
    addr0 = 64'h40; addr1 = 64'h80; wdata0 = 64'h5; wdata1 = 64'h6;

    // Reset held with both ports requesting
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", s_gnt, 2'b00);
      check("rst_rvalid", s_rvalid, 2'b00);
      check("rst_mem_wr", s_wr, 1'b0);
      check("rst_mem_raddr", s_raddr, 64'h0);
    end
    rst_n = 1'b1; req = 2'b00;

    for (int i = 0; i < 6; i++)
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_gnt, vecs[i].exp_data);

    // Simultaneous writes right after reset: port 0 first, port 1 two cycles later
    do_reset();
    sb_g0 = 0; sb_g1 = 0; sb_cf = 0;
    @(negedge clk);
    req = 2'b11; we = 2'b11;
    addr0 = 64'h8; wdata0 = 64'h11; addr1 = 64'h10; wdata1 = 64'h22;
    @(negedge clk);
    check("t3_gnt_a", s_gnt, 2'b01);
    check("t3_wr_a", s_wr, 1'b1);
    check("t3_waddr_a", s_waddr, 64'h8);
    check("t3_din_a", s_din, 64'h11);
    req[0] = 1'b0; sb_g0++; sb_cf++;
    @(negedge clk);
    check("t3_wr_gap", s_wr, 1'b0);
    check("t3_gnt_gap", s_gnt, 2'b00);
    @(negedge clk);
    check("t3_gnt_b", s_gnt, 2'b10);
    check("t3_wr_b", s_wr, 1'b1);
    check("t3_waddr_b", s_waddr, 64'h10);
    check("t3_din_b", s_din, 64'h22);
    req[1] = 1'b0; sb_g1++;
    @(negedge clk);

    // Port 1 streams reads; port 0 joins mid-stream; grants must then alternate
    @(negedge clk);
    req = 2'b10; we = 2'b00; addr1 = 64'h2000; addr0 = 64'h1000;
    pa[0] = '0; pa[1] = '0;
    ng = 0; nrv = 0; lastc = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 1) req[0] = 1'b1;
      if (s_gnt != 2'b00) begin
        p = s_gnt[1];
        if (ng < 9) begin
          expp = (ng % 2 == 0) ? 1 : 0;
          check("t4_order", p, expp);
          if (expp == 1) sb_g1++; else sb_g0++;
          if (ng > 0) begin
            check("t4_spacing", c - lastc, 4);
            sb_cf++;
          end
        end
        lastc = c;
        ng++;
        pa[p] = p ? addr1 : addr0;
        if (ng >= 9) req = 2'b00;
        else if (p) addr1 = addr1 + 64'h8;
        else addr0 = addr0 + 64'h8;
      end
      if (s_rvalid != 2'b00) begin
        check("t4_rdata", s_rdata, memf(pa[s_rvalid[1]]));
        nrv++;
      end
      if (ng >= 9 && c >= lastc + 3) break;
    end
    check("t4_grants", ng, 9);
    check("t4_rvalids", nrv, 9);
`ifdef DMEM_ARB_STATS_EN
    check("stat_gnt_cnt0", g0_1, sb_g0);
    check("stat_gnt_cnt1", g1_1, sb_g1);
    check("stat_conflict_cnt", cf_1, sb_cf);
`endif

    // RD_LAT=3: reset lands in the second WAIT cycle of a port 1 read
    do_reset();
    sel3 = 1'b1;
    @(negedge clk);
    req = 2'b10; we = 2'b00; addr1 = 64'h200; addr0 = 64'h300;
    @(negedge clk);
    check("t5_gnt", s_gnt, 2'b10);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_rvalid", s_rvalid, 2'b00);
    check("t5_rst_wr", s_wr, 1'b0);
    check("t5_rst_gnt", s_gnt, 2'b00);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t5_no_rvalid", s_rvalid, 2'b00);
    end
    txn(1'b1, 1'b0, 64'h208, 64'h0, 2'b10, memf(64'h208));

    do_reset();
    sel3 = 1'b1;
    rand_run(300);
    do_reset();
    sel3 = 1'b0;
    rand_run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
